alu_exec_stage: RTL and testbench

- Two-register execute stage that sits directly upstream and downstream of the combinational ALU.
- E1 takes decoded instructions under valid/ready, selects the register or immediate B operand, and drives the ALU's A, B, Opcode and cin.
- E2 captures the ALU result, owns the processor status register (PSR) and presents writeback to the register file under valid/ready.
- MOV and NOP are resolved here, not in the ALU.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_exec_stage_psr.sv | 38 +++
 rtl/alu_exec_stage.sv | 156 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute path.
//   - ALU opcode encodings (4 bits)
//   - Flag bit positions inside the 5-bit flag/PSR vector: [4]Z [3]C [2]O [1]L [0]N
//   - Default datapath width
//   - Opcode classification helpers used to gate PSR updates and writeback
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_ASHU = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    // PSR write masks for the two classes of flag-producing instructions
    localparam logic [4:0] MASK_CO  = 5'((1 << FLAG_C) | (1 << FLAG_O));
    localparam logic [4:0] MASK_ZLN = 5'((1 << FLAG_Z) | (1 << FLAG_L) | (1 << FLAG_N));

    // Arithmetic ops that own carry and overflow (ADDU deliberately excluded)
    function automatic logic sets_co(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB) || (op == OP_SUBC);
    endfunction

    // Only compare owns zero / low / negative
    function automatic logic sets_zln(input logic [3:0] op);
        return (op == OP_CMP);
    endfunction

    // NOP, CMP and the two undefined encodings never write a register
    function automatic logic writes_reg(input logic [3:0] op);
        logic wr;
        case (op)
            OP_NOP, OP_CMP, 4'b1110, 4'b1111: wr = 1'b0;
            default:                          wr = 1'b1;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/alu_exec_stage_psr.sv
// Processor status register with per-bit masked update.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears all bits)
//   en          update strobe
//   mask        bits that take d when en is high; others hold
//   d           new flag values
//   q           current register contents
module psr_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign q_next[gi] = (en & mask[gi]) ? d[gi] : q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register execute stage wrapped around an external combinational ALU.
//   E1: accepts a decoded instruction (in_valid/in_ready), resolves the B
//       operand (register or extended immediate) and drives the ALU inputs.
//   E2: captures the ALU result (or the B operand for MOV), updates the PSR
//       and presents the writeback entry (out_valid/out_ready).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_*                 decoded instruction and handshake
//   flush                synchronous kill of both stages
//   alu_a/b/opcode/cin   to the ALU; alu_c/alu_flags back from it
//   out_*                writeback entry and handshake
//   psr                  status register {Z,C,O,L,N}
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int IMM_W  = 8,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_imm_sel,
    input  logic              in_imm_sext,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wb_en,
    input  logic              flush,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [WIDTH-1:0]  alu_c,
    input  logic [4:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wb_en,
    output logic [4:0]        psr
);

    // E1 state
    logic              e1_valid_reg;
    logic [WIDTH-1:0]  e1_a_reg;
    logic [WIDTH-1:0]  e1_b_reg;
    logic [3:0]        e1_op_reg;
    logic [REG_AW-1:0] e1_dest_reg;
    logic              e1_wb_en_reg;

    // E2 state
    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_result_reg;
    logic [REG_AW-1:0] out_dest_reg;
    logic              out_wb_en_reg;

    logic              e2_load;
    logic              accept;
    logic [WIDTH-1:0]  imm_ext;
    logic [WIDTH-1:0]  b_next;
    logic [WIDTH-1:0]  result_next;
    logic              wb_en_next;
    logic [4:0]        psr_mask;

    // Handshake: E1 moves into E2 whenever E2 is empty or draining
    assign e2_load  = e1_valid_reg & (~out_valid_reg | out_ready) & ~flush;
    assign in_ready = (~e1_valid_reg | e2_load) & ~flush;
    assign accept   = in_valid & in_ready;

    // A sign-extended negative immediate lets LSH/ASHU express right shifts
    assign imm_ext = {{(WIDTH-IMM_W){in_imm_sext & in_imm[IMM_W-1]}}, in_imm};
    assign b_next  = in_imm_sel ? imm_ext : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid_reg <= 1'b0;
            e1_a_reg     <= '0;
            e1_b_reg     <= '0;
            e1_op_reg    <= '0;
            e1_dest_reg  <= '0;
            e1_wb_en_reg <= 1'b0;
        end else if (flush) begin
            e1_valid_reg <= 1'b0;
        end else if (accept) begin
            e1_valid_reg <= 1'b1;
            e1_a_reg     <= in_a;
            e1_b_reg     <= b_next;
            e1_op_reg    <= in_opcode;
            e1_dest_reg  <= in_dest;
            e1_wb_en_reg <= in_wb_en;
        end else if (e2_load) begin
            // Operand registers keep their last value; only validity drops
            e1_valid_reg <= 1'b0;
        end
    end

    assign alu_a      = e1_a_reg;
    assign alu_b      = e1_b_reg;
    assign alu_opcode = e1_op_reg;

    // MOV bypasses the ALU entirely
    assign result_next = (e1_op_reg == OP_MOV) ? e1_b_reg : alu_c;
    assign wb_en_next  = e1_wb_en_reg & writes_reg(e1_op_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_dest_reg   <= '0;
            out_wb_en_reg  <= 1'b0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
        end else if (e2_load) begin
            out_valid_reg  <= 1'b1;
            out_result_reg <= result_next;
            out_dest_reg   <= e1_dest_reg;
            out_wb_en_reg  <= wb_en_next;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_dest   = out_dest_reg;
    assign out_wb_en  = out_wb_en_reg;

    // PSR is written on the E1->E2 transfer so the next instruction (now in
    // E1) already sees the updated carry: ADDC chains without a bubble.
    always_comb begin
        psr_mask = '0;
        if (sets_co(e1_op_reg)) begin
            psr_mask = MASK_CO;
        end else if (sets_zln(e1_op_reg)) begin
            psr_mask = MASK_ZLN;
        end
    end

    psr_reg #(
        .W(5)
    ) u_psr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (e2_load),
        .mask  (psr_mask),
        .d     (alu_flags),
        .q     (psr)
    );

    assign alu_cin = psr[FLAG_C];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with a small behavioural ALU model.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [W-1:0]  in_a, in_b;
    logic [7:0]    in_imm;
    logic          in_imm_sel, in_imm_sext;
    logic [3:0]    in_dest;
    logic          in_wb_en;
    logic          flush;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_opcode;
    logic          alu_cin;
    logic [W-1:0]  alu_c;
    logic [4:0]    alu_flags;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_dest;
    logic          out_wb_en;
    logic [4:0]    psr;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_stage #(.WIDTH(W), .IMM_W(8), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_imm_sel(in_imm_sel),
        .in_imm_sext(in_imm_sext), .in_dest(in_dest), .in_wb_en(in_wb_en),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dest(out_dest), .out_wb_en(out_wb_en), .psr(psr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU. Flags are produced for every opcode so that a wrong
    // PSR mask in the stage shows up as a changed PSR.
    logic [W:0] sum, diff;
    int         amt;
    logic       f_c, f_o;
    always_comb begin
        alu_c = '0;
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        diff  = {1'b0, alu_a} - {1'b0, alu_b};
        amt   = int'($signed(alu_b));
        f_c   = sum[W];
        f_o   = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        case (alu_opcode)
            OP_AND:  alu_c = alu_a & alu_b;
            OP_OR:   alu_c = alu_a | alu_b;
            OP_XOR:  alu_c = alu_a ^ alu_b;
            OP_NOT:  alu_c = ~alu_a;
            OP_ADD, OP_ADDU: alu_c = sum[W-1:0];
            OP_ADDC: begin
                sum   = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
                alu_c = sum[W-1:0];
                f_c   = sum[W];
                f_o   = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            OP_SUB, OP_SUBC: begin
                if (alu_opcode == OP_SUBC)
                    diff = {1'b0, alu_a} - {1'b0, alu_b} - {{W{1'b0}}, alu_cin};
                alu_c = diff[W-1:0];
                f_c   = diff[W];
                f_o   = (alu_a[W-1] != alu_b[W-1]) && (diff[W-1] != alu_a[W-1]);
            end
            OP_LSH:  alu_c = (amt < 0) ? (alu_a >> (-amt)) : (alu_a << amt);
            OP_ASHU: alu_c = (amt < 0) ? W'($signed(alu_a) >>> (-amt)) : (alu_a << amt);
            default: alu_c = '0;
        endcase
        alu_flags = {alu_a == alu_b, f_c, f_o, alu_a < alu_b, $signed(alu_a) < $signed(alu_b)};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] imm, input logic sel, input logic sext,
                         input logic [3:0] dest, input logic wb);
        in_opcode = op; in_a = a; in_b = b; in_imm = imm;
        in_imm_sel = sel; in_imm_sext = sext; in_dest = dest; in_wb_en = wb;
        in_valid = 1'b1;
    endtask

    // Offer one instruction and return 1 time unit after the accepting edge
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] imm, input logic sel, input logic sext,
                        input logic [3:0] dest, input logic wb);
        int n = 0;
        drive(op, a, b, imm, sel, sext, dest, wb);
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send then advance one more edge so the result sits in E2
    task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] imm, input logic sel, input logic sext,
                       input logic [3:0] dest, input logic wb);
        send(op, a, b, imm, sel, sext, dest, wb);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op_undef;
        op_undef = 4'b1110;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(OP_NOP, 16'h0, 16'h0, 8'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_psr", {27'd0, psr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", {16'd0, out_result}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with signed overflow, checking two-edge latency
        send(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", {16'd0, out_result}, 32'h8000);
        chk("add_dest", {28'd0, out_dest}, 32'd3);
        chk("add_wb", {31'd0, out_wb_en}, 32'd1);
        chk("add_psr", {27'd0, psr}, 32'b00100);

        // ADD then ADDC back-to-back: carry chains with no bubble
        send(OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1);
        send(OP_ADDC, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 4'd2, 1'b1);
        chk("chain1_result", {16'd0, out_result}, 32'h0000);
        chk("chain1_psr", {27'd0, psr}, 32'b01000);
        @(posedge clk); #1;
        chk("chain2_valid", {31'd0, out_valid}, 32'd1);
        chk("chain2_result", {16'd0, out_result}, 32'h0001);
        chk("chain2_dest", {28'd0, out_dest}, 32'd2);
        chk("chain2_psr", {27'd0, psr}, 32'b00000);

        // CMP: Z/L/N written, C/O kept from the preceding ADD
        run(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd4, 1'b1);
        chk("pre_cmp_psr", {27'd0, psr}, 32'b00100);
        run(OP_CMP, 16'h0003, 16'hFFFE, 8'h00, 1'b0, 1'b0, 4'd4, 1'b1);
        chk("cmp_wb", {31'd0, out_wb_en}, 32'd0);
        chk("cmp_psr", {27'd0, psr}, 32'b00110);

        // Immediate extension feeding shifts, MOV, NOP and undefined opcode
        run(OP_LSH, 16'h00F0, 16'h1234, 8'hFC, 1'b1, 1'b1, 4'd5, 1'b1);
        chk("lsh_sext", {16'd0, out_result}, 32'h000F);
        chk("lsh_psr", {27'd0, psr}, 32'b00110);
        run(OP_LSH, 16'h00F0, 16'h1234, 8'hFC, 1'b1, 1'b0, 4'd5, 1'b1);
        chk("lsh_zext", {16'd0, out_result}, 32'h0000);
        run(OP_ASHU, 16'h8000, 16'h0000, 8'hFF, 1'b1, 1'b1, 4'd6, 1'b1);
        chk("ashu_result", {16'd0, out_result}, 32'hC000);
        run(OP_MOV, 16'h1111, 16'h2222, 8'h80, 1'b1, 1'b1, 4'd7, 1'b1);
        chk("mov_result", {16'd0, out_result}, 32'hFF80);
        chk("mov_wb", {31'd0, out_wb_en}, 32'd1);
        run(OP_MOV, 16'h1111, 16'h2222, 8'h80, 1'b0, 1'b1, 4'd7, 1'b1);
        chk("mov_reg", {16'd0, out_result}, 32'h2222);
        run(OP_NOP, 16'h0005, 16'h0005, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1);
        chk("nop_wb", {31'd0, out_wb_en}, 32'd0);
        run(op_undef, 16'h0001, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd9, 1'b1);
        chk("undef_wb", {31'd0, out_wb_en}, 32'd0);
        chk("undef_result", {16'd0, out_result}, 32'h0000);
        chk("undef_psr", {27'd0, psr}, 32'b00110);
        run(OP_SUB, 16'h0001, 16'h0002, 8'h00, 1'b0, 1'b0, 4'd10, 1'b1);
        chk("sub_result", {16'd0, out_result}, 32'hFFFF);
        chk("sub_psr", {27'd0, psr}, 32'b01010);
        @(posedge clk); #1;
        chk("drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three instructions offered while out_ready is low
        out_ready = 1'b0;
        drive(OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1);
        @(posedge clk); #1;
        chk("bp_e1_only", {31'd0, out_valid}, 32'd0);
        drive(OP_ADDC, 16'h0010, 16'h0020, 8'h00, 1'b0, 1'b0, 4'd2, 1'b1);
        @(posedge clk); #1;
        drive(OP_ADD, 16'h0100, 16'h0200, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1);
        chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("bp_ready_still_low", {31'd0, in_ready}, 32'd0);
        chk("bp_alu_a", {16'd0, alu_a}, 32'h0010);
        chk("bp_alu_b", {16'd0, alu_b}, 32'h0020);
        chk("bp_cin", {31'd0, alu_cin}, 32'd1);
        chk("bp_hold_result", {16'd0, out_result}, 32'h0000);
        chk("bp_hold_dest", {28'd0, out_dest}, 32'd1);
        chk("bp_hold_psr", {27'd0, psr}, 32'b01010);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_result", {16'd0, out_result}, 32'h0031);
        chk("bp_second_dest", {28'd0, out_dest}, 32'd2);
        chk("bp_second_psr", {27'd0, psr}, 32'b00010);
        @(posedge clk); #1;
        chk("bp_third_result", {16'd0, out_result}, 32'h0300);
        chk("bp_third_dest", {28'd0, out_dest}, 32'd3);
        @(posedge clk); #1;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush with SUB in E1 and MOV held in E2
        out_ready = 1'b0;
        send(OP_MOV, 16'h0000, 16'h0000, 8'h55, 1'b1, 1'b0, 4'd5, 1'b1);
        send(OP_SUB, 16'h0001, 16'h0002, 8'h00, 1'b0, 1'b0, 4'd6, 1'b1);
        chk("fl_e2_mov", {16'd0, out_result}, 32'h0055);
        chk("fl_e1_sub", {28'd0, alu_opcode}, {28'd0, OP_SUB});
        drive(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd7, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_psr", {27'd0, psr}, 32'b00010);
        @(posedge clk); #1;
        chk("fl_e1_killed", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of traffic
        run(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 1'b0, 4'd9, 1'b1);
        chk("pre_rst_psr", {27'd0, psr}, 32'b00110);
        send(OP_AND, 16'h00FF, 16'h0F0F, 8'h00, 1'b0, 1'b0, 4'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_psr", {27'd0, psr}, 32'd0);
        chk("arst_result", {16'd0, out_result}, 32'd0);
        chk("arst_dest", {28'd0, out_dest}, 32'd0);
        chk("arst_alu_a", {16'd0, alu_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
